// File: rtl/mini_cpu_pkg.sv
// Shared definitions for the parametrised mini CPU: opcodes, FSM encoding
// and instruction field geometry derived from the register address width.
package mini_cpu_pkg;

    localparam logic [1:0] OP_IN  = 2'b00;
    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_MOV = 2'b10;
    localparam logic [1:0] OP_OUT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_EXEC     = 2'd1,
        ST_WAIT_IN  = 2'd2,
        ST_WAIT_OUT = 2'd3
    } state_t;

    // Instruction layout is {op[1:0], dest[RA-1:0], src[RA-1:0]}.
    function automatic int instr_w(input int ra);
        return 2 + 2 * ra;
    endfunction

    function automatic int dest_lsb(input int ra);
        return ra;
    endfunction

    function automatic int op_lsb(input int ra);
        return 2 * ra;
    endfunction

endpackage

// File: rtl/mini_cpu_param_if.sv
// Instruction, input and output channels of the mini CPU plus its status flags.
// The master side is the sequencer/FIFO environment, the slave side is the core.
interface mini_cpu_param_if #(
    parameter int W  = 8,
    parameter int RA = 3
);
    import mini_cpu_pkg::*;

    localparam int IW = instr_w(RA);

    logic [IW-1:0] instr;
    logic          instr_valid;
    logic          instr_ready;
    logic [W-1:0]  in_data;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  out_data;
    logic          out_valid;
    logic          out_ready;
    logic          carry;
    logic          zero;
    logic          busy;

    modport master (
        output instr, instr_valid, in_data, in_valid, out_ready,
        input  instr_ready, in_ready, out_data, out_valid, carry, zero, busy
    );

    modport slave (
        input  instr, instr_valid, in_data, in_valid, out_ready,
        output instr_ready, in_ready, out_data, out_valid, carry, zero, busy
    );

endinterface

// File: rtl/mini_cpu_regfile.sv
// NREG x W register file: two combinational read ports, one synchronous write
// port and a synchronous clear that zeroes every register.
module mini_cpu_regfile #(
    parameter int W  = 8,
    parameter int RA = 3
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          we,
    input  logic [RA-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [RA-1:0] raddr_a,
    output logic [W-1:0]  rdata_a,
    input  logic [RA-1:0] raddr_b,
    output logic [W-1:0]  rdata_b
);
    localparam int NREG = 1 << RA;

    logic [W-1:0] regs_q [NREG];

    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
            always_ff @(posedge clk) begin
                if (clr) begin
                    regs_q[gi] <= '0;
                end else if (we && (waddr == RA'(gi))) begin
                    regs_q[gi] <= wdata;
                end
            end
        end
    endgenerate

    assign rdata_a = regs_q[raddr_a];
    assign rdata_b = regs_q[raddr_b];

endmodule

// File: rtl/mini_cpu_param.sv
// Four-instruction register-file core (IN/ADD/MOV/OUT) with carry/zero flags,
// optional saturating add and valid/ready handshakes on every channel.
module mini_cpu_param
    import mini_cpu_pkg::*;
#(
    parameter int W   = 8,
    parameter int RA  = 3,
    parameter int SAT = 0
) (
    input  logic             clk,
    input  logic             rst,
    mini_cpu_param_if.slave  bus
);
    localparam int IW = instr_w(RA);
    localparam int DL = dest_lsb(RA);
    localparam int OL = op_lsb(RA);

    state_t        state_q, state_d;
    logic [IW-1:0] instr_q, instr_d;
    logic [W-1:0]  out_data_q, out_data_d;
    logic          out_valid_q, out_valid_d;
    logic          carry_q, carry_d;
    logic          zero_q, zero_d;

    logic [1:0]    op_q;
    logic [RA-1:0] dest_q, src_q, rd_src_addr;
    logic [1:0]    new_op;
    logic [W-1:0]  rd_src, rd_dest;
    logic [W:0]    sum;
    logic [W-1:0]  add_result;
    logic          rf_we;
    logic [W-1:0]  rf_wdata;
    logic          instr_ready, in_ready;

    assign op_q   = instr_q[OL +: 2];
    assign dest_q = instr_q[DL +: RA];
    assign src_q  = instr_q[RA-1:0];
    assign new_op = bus.instr[OL +: 2];

    // OUT loads out_data while the instruction is being accepted, so the
    // source port looks at the incoming instruction while idle.
    assign rd_src_addr = (state_q == ST_IDLE) ? bus.instr[RA-1:0] : src_q;

    mini_cpu_regfile #(.W(W), .RA(RA)) u_regfile (
        .clk     (clk),
        .clr     (rst),
        .we      (rf_we),
        .waddr   (dest_q),
        .wdata   (rf_wdata),
        .raddr_a (rd_src_addr),
        .rdata_a (rd_src),
        .raddr_b (dest_q),
        .rdata_b (rd_dest)
    );

    assign sum        = {1'b0, rd_dest} + {1'b0, rd_src};
    assign add_result = ((SAT != 0) && sum[W]) ? {W{1'b1}} : sum[W-1:0];

    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        carry_d     = carry_q;
        zero_d      = zero_q;
        rf_we       = 1'b0;
        rf_wdata    = rd_src;
        instr_ready = 1'b0;
        in_ready    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                instr_ready = 1'b1;
                if (bus.instr_valid) begin
                    instr_d = bus.instr;
                    case (new_op)
                        OP_IN:  state_d = ST_WAIT_IN;
                        OP_OUT: begin
                            state_d     = ST_WAIT_OUT;
                            out_data_d  = rd_src;
                            out_valid_d = 1'b1;
                        end
                        default: state_d = ST_EXEC;
                    endcase
                end
            end
            ST_EXEC: begin
                rf_we   = 1'b1;
                state_d = ST_IDLE;
                if (op_q == OP_ADD) begin
                    rf_wdata = add_result;
                    carry_d  = sum[W];
                    zero_d   = (add_result == '0);
                end
            end
            ST_WAIT_IN: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    rf_we    = 1'b1;
                    rf_wdata = bus.in_data;
                    state_d  = ST_IDLE;
                end
            end
            ST_WAIT_OUT: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            instr_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            instr_q     <= instr_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            carry_q     <= carry_d;
            zero_q      <= zero_d;
        end
    end

    assign bus.instr_ready = instr_ready;
    assign bus.in_ready    = in_ready;
    assign bus.out_data    = out_data_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.carry       = carry_q;
    assign bus.zero        = zero_q;
    assign bus.busy        = (state_q != ST_IDLE);

endmodule
